// File: rtl/hap_pkg.sv
// Shared constants for the HAP compare pipeline: opcode encodings and flag bit positions.
package hap_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_LT  = 5'b01011;
  localparam logic [OPW-1:0] OP_GT  = 5'b01100;
  localparam logic [OPW-1:0] OP_EQ  = 5'b01101;
  localparam logic [OPW-1:0] OP_GTE = 5'b01110;
  localparam logic [OPW-1:0] OP_LTE = 5'b01111;
  localparam logic [OPW-1:0] OP_NE  = 5'b10000;
  localparam logic [OPW-1:0] OP_MIN = 5'b10001;
  localparam logic [OPW-1:0] OP_MAX = 5'b10010;

  // Bit positions inside the 4-bit sticky flags register.
  typedef enum logic [1:0] {
    FLG_LT  = 2'd0,
    FLG_EQ  = 2'd1,
    FLG_GT  = 2'd2,
    FLG_ERR = 2'd3
  } flag_idx_e;

endpackage

// File: rtl/hap_cmp_core.sv
// Combinational magnitude comparator; signed mode flips the MSB of both operands so
// an unsigned compare orders two's-complement values correctly.
module hap_cmp_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sgn,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt
);

  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  assign w_flip = {i_sgn, {(WIDTH-1){1'b0}}};
  assign w_a    = i_a ^ w_flip;
  assign w_b    = i_b ^ w_flip;

  assign o_lt = (w_a < w_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = ~o_lt & ~o_eq;

endmodule

// File: rtl/hap_compare_pipe.sv
// Two-stage pipelined HAP compare unit with valid/ready on both sides and a sticky
// flags register. Optional MIN/MAX opcodes are enabled by defining CMP_MINMAX_EN.
module hap_compare_pipe
  import hap_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = hap_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic             sgn,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RD,
  output logic [3:0]       flags
);

  // Stage 1 (capture) registers
  logic             r_s1_full;
  logic [OPW-1:0]   r_s1_op;
  logic             r_s1_sgn;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2 (result) registers
  logic             r_s2_full;
  logic [WIDTH-1:0] r_rd;
  logic [3:0]       r_flags;

  logic             w_stall;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  logic             w_err;
  logic [WIDTH-1:0] w_rd;
  logic [3:0]       w_flags;

  // A held result blocks the whole pipe; stage 1 may still fill if it is empty.
  assign w_stall   = r_s2_full & ~out_ready;
  assign in_ready  = ~w_stall | ~r_s1_full;
  assign out_valid = r_s2_full;
  assign RD        = r_rd;
  assign flags     = r_flags;

  hap_cmp_core #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_sgn (r_s1_sgn),
    .o_lt  (w_lt),
    .o_eq  (w_eq),
    .o_gt  (w_gt)
  );

  // Predicate select and flag formation from the stage-1 operands
  always_comb begin
    w_rd  = '0;
    w_err = 1'b0;
    case (r_s1_op)
      OP_LT:  w_rd[0] = w_lt;
      OP_GT:  w_rd[0] = w_gt;
      OP_EQ:  w_rd[0] = w_eq;
      OP_GTE: w_rd[0] = ~w_lt;
      OP_LTE: w_rd[0] = ~w_gt;
      OP_NE:  w_rd[0] = ~w_eq;
`ifdef CMP_MINMAX_EN
      OP_MIN: w_rd = w_lt ? r_s1_a : r_s1_b;
      OP_MAX: w_rd = w_lt ? r_s1_b : r_s1_a;  // tie returns R1
`else
      OP_MIN, OP_MAX: w_err = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase

    w_flags          = '0;
    w_flags[FLG_ERR] = w_err;
    w_flags[FLG_LT]  = w_lt & ~w_err;
    w_flags[FLG_EQ]  = w_eq & ~w_err;
    w_flags[FLG_GT]  = w_gt & ~w_err;
  end

  // Stage 1: capture a beat whenever the unit is ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_full <= 1'b0;
      r_s1_op   <= '0;
      r_s1_sgn  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
    end else if (in_ready) begin
      r_s1_full <= in_valid;
      if (in_valid) begin
        r_s1_op  <= opcode;
        r_s1_sgn <= sgn;
        r_s1_a   <= R1;
        r_s1_b   <= R2;
      end
    end
  end

  // Stage 2: register result and sticky flags when not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_full <= 1'b0;
      r_rd      <= '0;
      r_flags   <= '0;
    end else if (!w_stall) begin
      r_s2_full <= r_s1_full;
      if (r_s1_full) begin
        r_rd    <= w_rd;
        r_flags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_hap_compare_pipe.sv
// Directed scoreboard bench for hap_compare_pipe (WIDTH=8). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_hap_compare_pipe;

  localparam logic [4:0] LT  = 5'b01011;
  localparam logic [4:0] GT  = 5'b01100;
  localparam logic [4:0] EQ  = 5'b01101;
  localparam logic [4:0] GTE = 5'b01110;
  localparam logic [4:0] LTE = 5'b01111;
  localparam logic [4:0] NE  = 5'b10000;
  localparam logic [4:0] MIN = 5'b10001;
  localparam logic [4:0] MAX = 5'b10010;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] opcode;
  logic       sgn;
  logic [7:0] R1;
  logic [7:0] R2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] RD;
  logic [3:0] flags;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_pop  = 0;
  int n_wait = 0;

  logic [11:0] sb[$];   // {rd, flags}
  string       tq[$];

  logic       stall_seen = 1'b0;
  logic [7:0] prev_rd;
  logic [3:0] prev_fl;

  always #5 clk = ~clk;

  hap_compare_pipe #(
    .WIDTH (8),
    .OPW   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .sgn       (sgn),
    .R1        (R1),
    .R2        (R2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RD        (RD),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written with signed casts rather than MSB flipping.
  function automatic logic [11:0] model(input logic [4:0] op, input logic s,
                                        input logic [7:0] a, input logic [7:0] b);
    logic lt, eq, gt, err;
    logic [7:0] rd;
    eq  = (a == b);
    lt  = s ? ($signed(a) < $signed(b)) : (a < b);
    gt  = !lt && !eq;
    err = 1'b0;
    rd  = 8'h00;
    case (op)
      LT:  rd[0] = lt;
      GT:  rd[0] = gt;
      EQ:  rd[0] = eq;
      GTE: rd[0] = gt || eq;
      LTE: rd[0] = lt || eq;
      NE:  rd[0] = !eq;
`ifdef CMP_MINMAX_EN
      MIN: rd = lt ? a : b;
      MAX: rd = (lt) ? b : a;
`endif
      default: err = 1'b1;
    endcase
    if (err) begin
      lt = 1'b0;
      eq = 1'b0;
      gt = 1'b0;
    end
    return {rd, err, gt, eq, lt};
  endfunction

  // Output monitor: scoreboard pop on transfer, stability check while stalled
  always @(negedge clk) begin
    if (!rst && stall_seen) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_rd", 32'(RD), 32'(prev_rd));
      check("stall_flags", 32'(flags), 32'(prev_fl));
    end
    stall_seen = !rst && out_valid && !out_ready;
    prev_rd    = RD;
    prev_fl    = flags;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        string t;
        e = sb.pop_front();
        t = tq.pop_front();
        check({t, "_rd"}, 32'(RD), 32'(e[11:4]));
        check({t, "_flags"}, 32'(flags), 32'(e[3:0]));
        n_pop++;
      end
    end
  end

  // Presents a beat and holds it until accepted; returns on posedge+1 of the accept edge.
  task automatic send(input logic [4:0] op, input logic s, input logic [7:0] a,
                      input logic [7:0] b);
    bit done = 1'b0;
    int waits = 0;
    in_valid = 1'b1;
    opcode   = op;
    sgn      = s;
    R1       = a;
    R2       = b;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, s, a, b));
        tq.push_back("stream");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) waits++;
    end
    if (!done) check("send_timeout", 32'd1, 32'd0);
    n_wait += waits;
  endtask

  // Single isolated beat with explicit expectation and exact latency check.
  task automatic single(input string tag, input logic [4:0] op, input logic s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_rd, input logic [3:0] exp_fl);
    in_valid = 1'b1;
    opcode   = op;
    sgn      = s;
    R1       = a;
    R2       = b;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back({exp_rd, exp_fl});
    tq.push_back(tag);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    logic [4:0] ops[6];
    ops = '{LT, GT, EQ, GTE, LTE, NE};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 5'd0;
    sgn       = 1'b0;
    R1        = 8'h00;
    R2        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_rd", 32'(RD), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Unsigned single beats
    single("lt_3_5", LT, 1'b0, 8'd3, 8'd5, 8'd1, 4'b0001);
    single("lt_5_3", LT, 1'b0, 8'd5, 8'd3, 8'd0, 4'b0100);
    single("gt_7_7", GT, 1'b0, 8'd7, 8'd7, 8'd0, 4'b0010);
    single("eq_2_2", EQ, 1'b0, 8'd2, 8'd2, 8'd1, 4'b0010);
    single("ne_2_2", NE, 1'b0, 8'd2, 8'd2, 8'd0, 4'b0010);
    single("gte_eq", GTE, 1'b0, 8'd9, 8'd9, 8'd1, 4'b0010);
    single("lte_eq", LTE, 1'b0, 8'd9, 8'd9, 8'd1, 4'b0010);

    // Signed edges
    single("gte_s1", GTE, 1'b1, 8'h80, 8'h01, 8'd0, 4'b0001);
    single("gte_s0", GTE, 1'b0, 8'h80, 8'h01, 8'd1, 4'b0100);
    single("lt_edge_s1", LT, 1'b1, 8'h80, 8'h7F, 8'd1, 4'b0001);
    single("lt_edge_s0", LT, 1'b0, 8'h80, 8'h7F, 8'd0, 4'b0100);

    // Illegal opcode then legal
    single("illegal", 5'b00001, 1'b0, 8'd7, 8'd3, 8'd0, 4'b1000);
    single("lte_7_3", LTE, 1'b0, 8'd7, 8'd3, 8'd0, 4'b0100);

    // Optional MIN/MAX opcodes
`ifdef CMP_MINMAX_EN
    single("min_s1", MIN, 1'b1, 8'hF0, 8'h10, 8'hF0, 4'b0001);
    single("min_s0", MIN, 1'b0, 8'hF0, 8'h10, 8'h10, 4'b0100);
    single("max_tie", MAX, 1'b0, 8'd4, 8'd4, 8'd4, 4'b0010);
`else
    single("min_off", MIN, 1'b1, 8'hF0, 8'h10, 8'h00, 4'b1000);
    single("max_off", MAX, 1'b0, 8'd4, 8'd4, 8'h00, 4'b1000);
`endif

    // 16 back-to-back beats, full throughput
    pop0   = n_pop;
    n_wait = 0;
    for (int i = 0; i < 16; i++) begin
      send(ops[i % 6], 1'(i % 2), 8'(i * 37), 8'(8'h80 ^ (i * 11)));
    end
    in_valid = 1'b0;
    check("b2b_waits", 32'(n_wait), 32'd0);
    drain();
    check("b2b_count", 32'(n_pop - pop0), 32'd16);

    // Stream with a 3-cycle consumer stall in the middle
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(ops[(i + 3) % 6], 1'(i % 3 == 0), 8'(i * 53 + 7), 8'(i * 29));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", 32'(n_pop - pop0), 32'd10);

    // Reset with two beats in flight
    send(LT, 1'b0, 8'd1, 8'd9);
    send(GT, 1'b0, 8'd9, 8'd1);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_rd", 32'(RD), 32'd0);
    sb.delete();
    tq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    single("post_rst_lt", LT, 1'b0, 8'd1, 8'd2, 8'd1, 4'b0001);
    repeat (3) @(posedge clk);
    #1;
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
